// File: rtl/fetch_controller.sv
// ============================================================================
// Module      : fetch_controller
// Description : Instruction-fetch sequencer feeding decode from a 1-cycle ROM.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module fetch_controller #(
    parameter int BITS        = 8,
    parameter int MEMORY_SIZE = 256,
    parameter int RESET_PC    = 0,
    parameter int COUNT_BITS  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [BITS-1:0]       pc,
    input  logic [BITS-1:0]       instruction,
    output logic [BITS-1:0]       instr,
    output logic [BITS-1:0]       instr_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    input  logic                  branch_taken,
    input  logic [BITS-1:0]       branch_target,
    input  logic                  halt,
    input  logic                  resume,
    output logic                  halted,
    output logic [COUNT_BITS-1:0] accepted_count
);

    localparam logic [BITS-1:0] RESET_ADDR = BITS'(RESET_PC);
    localparam logic [BITS-1:0] LAST_ADDR  = BITS'(MEMORY_SIZE - 1);

    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    logic [1:0]      state;
    logic [BITS-1:0] fetch_pc;
    logic [BITS-1:0] req_pc;
    logic            req_valid;
    logic [BITS-1:0] restart_pc;
    logic            transfer;
    logic            stall;

    function automatic logic [BITS-1:0] inc(input logic [BITS-1:0] x);
        return (x == LAST_ADDR) ? '0 : x + BITS'(1);
    endfunction

    assign instr       = instruction;
    assign instr_pc    = req_pc;
    assign halted      = (state == ST_HALT);
    assign instr_valid = req_valid & (state == ST_RUN) & ~branch_taken;
    assign transfer    = instr_valid & instr_ready;
    assign stall       = req_valid & ~instr_ready;

    // Re-presenting req_pc during a stall keeps the ROM output stable with no skid buffer.
    always_comb begin
        pc = fetch_pc;
        if (rst) begin
            pc = RESET_ADDR;
        end else begin
            case (state)
                ST_BOOT: pc = RESET_ADDR;
                ST_RUN: begin
                    if (branch_taken)     pc = branch_target;
                    else if (halt)        pc = req_pc;
                    else if (stall)       pc = req_pc;
                    else                  pc = fetch_pc;
                end
                ST_HALT: pc = restart_pc;
                default: pc = RESET_ADDR;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_BOOT;
            fetch_pc       <= RESET_ADDR;
            req_pc         <= '0;
            req_valid      <= 1'b0;
            restart_pc     <= RESET_ADDR;
            accepted_count <= '0;
        end else begin
            if (transfer && (accepted_count != {COUNT_BITS{1'b1}}))
                accepted_count <= accepted_count + COUNT_BITS'(1);

            case (state)
                ST_BOOT: begin
                    state     <= ST_RUN;
                    req_valid <= 1'b1;
                    req_pc    <= RESET_ADDR;
                    fetch_pc  <= inc(RESET_ADDR);
                end
                ST_RUN: begin
                    if (branch_taken) begin
                        req_pc    <= branch_target;
                        req_valid <= 1'b1;
                        fetch_pc  <= inc(branch_target);
                    end else if (halt) begin
                        state      <= ST_HALT;
                        req_valid  <= 1'b0;
                        restart_pc <= transfer ? inc(req_pc) : req_pc;
                    end else if (!stall) begin
                        req_pc    <= fetch_pc;
                        req_valid <= 1'b1;
                        fetch_pc  <= inc(fetch_pc);
                    end
                end
                ST_HALT: begin
                    if (resume) begin
                        state     <= ST_RUN;
                        req_pc    <= restart_pc;
                        req_valid <= 1'b1;
                        fetch_pc  <= inc(restart_pc);
                    end
                end
                default: state <= ST_BOOT;
            endcase
        end
    end

endmodule

`default_nettype wire
